song_recorder: RTL and testbench

- Writer counterpart to song_reader: captures live key presses, measured in beats, and encodes them into the song-memory entry format that song_reader plays back.
- Sits between the key/button front end and the song RAM write port; shares the beat_generator tick with notes_player.
- Monophonic notes plus rests; one song slot is recorded per session.

---
 rtl/song_recorder_pkg.sv | 47 ++++
 rtl/song_recorder_duration_counter.sv | 40 ++++
 rtl/song_recorder.sv | 180 ++++++++++++++++++
 tb/tb_song_recorder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/song_recorder_pkg.sv
// rtl/song_recorder_pkg.sv - song_recorder constants, state encoding and entry packing (optional RECORDER_GLITCH_FILTER_EN in top)
package song_recorder_pkg;

  // Song slot geometry. The last index of a slot always holds the end marker.
  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
  localparam int SONG_W  = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  // Entry layout: [15] rest, [14:9] note, [8:6] meta, [5:0] duration in beats.
  localparam int ENTRY_W   = 16;
  localparam int DUR_W     = 6;
  localparam int NOTE_W    = 6;
  localparam int META_W    = 3;
  localparam int REST_FLAG = 15;
  localparam int NOTE_LSB  = 9;
  localparam int META_LSB  = 6;
  localparam int DUR_LSB   = 0;
  localparam logic [DUR_W-1:0]   DUR_MAX    = 6'd63;
  localparam logic [ENTRY_W-1:0] END_MARKER = 16'h0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    HOLD   = 3'd2,
    REST   = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5
  } rec_state_t;

  // Rest entries carry no note or metadata, only the duration.
  function automatic logic [ENTRY_W-1:0] make_entry(
    input logic              rest,
    input logic [NOTE_W-1:0] note,
    input logic [META_W-1:0] meta,
    input logic [DUR_W-1:0]  dur
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[REST_FLAG] = rest;
    e[NOTE_LSB +: NOTE_W] = rest ? '0 : note;
    e[META_LSB +: META_W] = rest ? '0 : meta;
    e[DUR_LSB +: DUR_W] = dur;
    return e;
  endfunction

endpackage

// File: rtl/song_recorder_duration_counter.sv
// rtl/song_recorder_duration_counter.sv - saturating beat counter with clear, preload-1 and at_max flag
module song_recorder_duration_counter
  import song_recorder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [DUR_W-1:0] count,
  output logic             at_max
);

  logic [DUR_W-1:0] count_q, count_d;

  // Preload-1 wins over clear (beat landing on the entry boundary); increments stop at DUR_MAX
  always_comb begin
    count_d = count_q;
    if (load1) begin
      count_d = DUR_W'(1);
    end else if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != DUR_MAX)) begin
      count_d = count_q + DUR_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == DUR_MAX);

endmodule

// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - records live key presses into song entries; RECORDER_GLITCH_FILTER_EN drops zero-beat entries
module song_recorder
  import song_recorder_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    record,
  input  logic [SONG_W-1:0]       song,
  input  logic                    key_valid,
  input  logic [NOTE_W-1:0]       key_note,
  input  logic [META_W-1:0]       key_meta,
  input  logic                    beat,
  output logic                    wr_en,
  output logic [SONG_W+IDX_W-1:0] wr_addr,
  output logic [ENTRY_W-1:0]      wr_data,
  output logic                    busy,
  output logic                    rec_done,
  output logic [IDX_W-1:0]        num_entries
);

  rec_state_t state_q, state_d;

  logic              record_prev_q, record_prev_d;
  logic              stop_q, stop_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  num_q, num_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [META_W-1:0] meta_q, meta_d;
  logic              rest_q, rest_d;
  logic              rec_done_q, rec_done_d;

  logic [DUR_W-1:0]  count;
  logic              at_max;
  logic              cnt_clr, cnt_load1, cnt_inc;

  logic              start, stop, key_changed, reach_max;
  logic              close_hold, close_rest, full, discard;
  rec_state_t        cont_state;

  song_recorder_duration_counter u_dur (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .load1  (cnt_load1),
    .inc    (cnt_inc),
    .count  (count),
    .at_max (at_max)
  );

  // A stop request is remembered so the entry write can still be followed by FINISH
  assign start       = (state_q == IDLE) && record && !record_prev_q;
  assign stop        = stop_q || !record;
  assign key_changed = key_valid && ((key_note != note_q) || (key_meta != meta_q));
  // A beat arriving at DUR_MAX-1 closes the entry on that same beat
  assign reach_max   = at_max || (beat && (count == DUR_MAX - DUR_W'(1)));
  assign close_hold  = stop || !key_valid || key_changed || reach_max;
  assign close_rest  = stop || key_valid || reach_max;
  assign full        = (index_q == LAST_IDX);
  assign cont_state  = stop ? FINISH : (key_valid ? HOLD : REST);

`ifdef RECORDER_GLITCH_FILTER_EN
  assign discard = (count == '0) && !beat;
`else
  assign discard = 1'b0;
`endif

  assign cnt_inc   = beat && ((state_q == HOLD) || (state_q == REST));
  assign cnt_load1 = beat && (state_q == WRITE);
  assign cnt_clr   = (state_q == IDLE) || (state_q == ARMED) || (state_q == WRITE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: closed entries go to WRITE, or FINISH once the slot is full
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARMED;
      ARMED: begin
        if (stop) state_d = FINISH;
        else if (key_valid) state_d = HOLD;
      end
      HOLD: begin
        if (close_hold) state_d = discard ? cont_state : (full ? FINISH : WRITE);
      end
      REST: begin
        if (close_rest) state_d = discard ? cont_state : (full ? FINISH : WRITE);
      end
      WRITE:   state_d = cont_state;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Session datapath: slot/index captured on start, entry latches follow the next state
  always_comb begin
    record_prev_d = record;
    stop_d        = (state_q == IDLE) ? 1'b0 : stop;
    song_d        = song_q;
    index_d       = index_q;
    num_d         = num_q;
    note_d        = note_q;
    meta_d        = meta_q;
    rest_d        = rest_q;
    rec_done_d    = (state_q == FINISH);
    if (start) begin
      song_d  = song;
      index_d = '0;
      num_d   = '0;
    end
    if (state_q == WRITE) begin
      index_d = index_q + IDX_W'(1);
      num_d   = num_q + IDX_W'(1);
    end
    if (state_d == HOLD) begin
      note_d = key_note;
      meta_d = key_meta;
      rest_d = 1'b0;
    end else if (state_d == REST) begin
      rest_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      record_prev_q <= 1'b0;
      stop_q        <= 1'b0;
      song_q        <= '0;
      index_q       <= '0;
      num_q         <= '0;
      note_q        <= '0;
      meta_q        <= '0;
      rest_q        <= 1'b0;
      rec_done_q    <= 1'b0;
    end else begin
      record_prev_q <= record_prev_d;
      stop_q        <= stop_d;
      song_q        <= song_d;
      index_q       <= index_d;
      num_q         <= num_d;
      note_q        <= note_d;
      meta_q        <= meta_d;
      rest_q        <= rest_d;
      rec_done_q    <= rec_done_d;
    end
  end

  // Write port outputs decoded from state; address and data are zero when not writing
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = END_MARKER;
    case (state_q)
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {song_q, index_q};
        wr_data = make_entry(rest_q, note_q, meta_q, (count == '0) ? DUR_W'(1) : count);
      end
      FINISH: begin
        wr_en   = 1'b1;
        wr_addr = {song_q, index_q};
        wr_data = END_MARKER;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign rec_done    = rec_done_q;
  assign num_entries = num_q;

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - directed vector and sequence bench for song_recorder
module tb_song_recorder;

  logic        clk;
  logic        reset;
  logic        record;
  logic [1:0]  song;
  logic        key_valid;
  logic [5:0]  key_note;
  logic [2:0]  key_meta;
  logic        beat;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        rec_done;
  logic [4:0]  num_entries;

  song_recorder dut (
    .clk         (clk),
    .reset       (reset),
    .record      (record),
    .song        (song),
    .key_valid   (key_valid),
    .key_note    (key_note),
    .key_meta    (key_meta),
    .beat        (beat),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .rec_done    (rec_done),
    .num_entries (num_entries)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        rec;
    logic [1:0]  sng;
    logic        kv;
    logic [5:0]  note;
    logic [2:0]  meta;
    logic        bt;
    logic [30:0] exp;
  } vec_t;

  vec_t vecs[15];

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0]  log_addr[$];
  logic [15:0] log_data[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (rec_done) done_cnt++;
  end

  function automatic logic [30:0] ex(input logic en, input logic [6:0] a, input logic [15:0] d,
                                     input logic b, input logic r, input logic [4:0] n);
    return {en, a, d, b, r, n};
  endfunction

  function automatic vec_t mk(input logic rec, input logic [1:0] sng, input logic kv,
                              input logic [5:0] note, input logic [2:0] meta, input logic bt,
                              input logic [30:0] exp);
    vec_t v;
    v.rec = rec; v.sng = sng; v.kv = kv; v.note = note; v.meta = meta; v.bt = bt; v.exp = exp;
    return v;
  endfunction

  function automatic logic [15:0] note_entry(input logic [5:0] n, input logic [2:0] m, input logic [5:0] d);
    return {1'b0, n, m, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_log(input string name, input int base, input int idx,
                           input logic [6:0] a, input logic [15:0] d);
    logic [31:0] act;
    if (base + idx < log_addr.size()) act = {9'd0, log_addr[base+idx], log_data[base+idx]};
    else act = 32'hDEAD_BEEF;
    check(name, act, {9'd0, a, d});
  endtask

  task automatic beat_pulse();
    beat = 1'b1;
    step();
    beat = 1'b0;
    step();
  endtask

  int base;
  int dbase;

  initial begin
    reset = 1'b0; record = 1'b0; song = 2'd0; key_valid = 1'b0;
    key_note = 6'd0; key_meta = 3'd0; beat = 1'b0;

    vecs[0]  = mk(1, 2, 0, 0,  0, 0, ex(0, 0,  16'h0000, 1, 0, 0));
    vecs[1]  = mk(1, 2, 1, 20, 1, 0, ex(0, 0,  16'h0000, 1, 0, 0));
    vecs[2]  = mk(1, 2, 1, 20, 1, 1, ex(0, 0,  16'h0000, 1, 0, 0));
    vecs[3]  = mk(1, 2, 1, 20, 1, 0, ex(0, 0,  16'h0000, 1, 0, 0));
    vecs[4]  = mk(1, 2, 1, 20, 1, 1, ex(0, 0,  16'h0000, 1, 0, 0));
    vecs[5]  = mk(1, 2, 1, 20, 1, 1, ex(0, 0,  16'h0000, 1, 0, 0));
    vecs[6]  = mk(1, 2, 0, 0,  0, 0, ex(1, 64, 16'h2843, 1, 0, 0));
    vecs[7]  = mk(1, 2, 0, 0,  0, 0, ex(0, 0,  16'h0000, 1, 0, 1));
    vecs[8]  = mk(1, 2, 0, 0,  0, 1, ex(0, 0,  16'h0000, 1, 0, 1));
    vecs[9]  = mk(1, 2, 0, 0,  0, 0, ex(0, 0,  16'h0000, 1, 0, 1));
    vecs[10] = mk(1, 2, 0, 0,  0, 1, ex(0, 0,  16'h0000, 1, 0, 1));
    vecs[11] = mk(0, 2, 0, 0,  0, 0, ex(1, 65, 16'h8002, 1, 0, 1));
    vecs[12] = mk(0, 2, 0, 0,  0, 0, ex(1, 66, 16'h0000, 1, 0, 2));
    vecs[13] = mk(0, 2, 0, 0,  0, 0, ex(0, 0,  16'h0000, 0, 1, 2));
    vecs[14] = mk(0, 2, 0, 0,  0, 0, ex(0, 0,  16'h0000, 0, 0, 2));

    step(3);
    check("reset_outputs", {1'b0, wr_en, wr_addr, wr_data, busy, rec_done, num_entries}, 32'd0);
    reset = 1'b1;
    step(2);

    // Basic note + rest + end marker, cycle by cycle
    for (int i = 0; i < 15; i++) begin
      record = vecs[i].rec; song = vecs[i].sng; key_valid = vecs[i].kv;
      key_note = vecs[i].note; key_meta = vecs[i].meta; beat = vecs[i].bt;
      step();
      check($sformatf("vec%0d", i), {1'b0, wr_en, wr_addr, wr_data, busy, rec_done, num_entries},
            {1'b0, vecs[i].exp});
    end
    beat = 1'b0;

    // 70-beat note splits at DUR_MAX
    base = log_addr.size();
    song = 2'd1; record = 1'b1; step();
    key_valid = 1'b1; key_note = 6'd5; key_meta = 3'd0; step();
    repeat (70) beat_pulse();
    key_valid = 1'b0; record = 1'b0; step(4);
    check("sat_count", log_addr.size() - base, 3);
    check_log("sat_e0", base, 0, 7'd32, 16'h0A3F);
    check_log("sat_e1", base, 1, 7'd33, 16'h0A07);
    check_log("sat_end", base, 2, 7'd34, 16'h0000);
    check("sat_num", {27'd0, num_entries}, 32'd2);

    // 32 one-beat notes fill the slot
    base = log_addr.size(); dbase = done_cnt;
    song = 2'd3; record = 1'b1; step();
    for (int k = 1; k <= 32; k++) begin
      key_valid = 1'b1; key_note = 6'(k); key_meta = 3'(k % 8);
      step(2);
      beat_pulse();
      step();
    end
    key_note = 6'd33; step(4);
    check("full_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      key_note = 6'(40 + k); step(2);
      beat_pulse();
    end
    key_valid = 1'b0; record = 1'b0; step(2);
    check("full_count", log_addr.size() - base, 32);
    for (int i = 0; i < 31; i++)
      check_log($sformatf("full_e%0d", i), base, i, 7'(96 + i),
                note_entry(6'(i + 1), 3'((i + 1) % 8), 6'd1));
    check_log("full_end", base, 31, 7'd127, 16'h0000);
    check("full_num", {27'd0, num_entries}, 32'd31);
    check("full_done", done_cnt - dbase, 1);

    // Beat coincident with key change, then beat inside the write cycle
    base = log_addr.size();
    song = 2'd0; record = 1'b1; step();
    key_valid = 1'b1; key_note = 6'd10; key_meta = 3'd2; step();
    beat_pulse();
    key_note = 6'd11; beat = 1'b1; step();
    check("coinc_wr_en", {31'd0, wr_en}, 32'd1);
    step();
    beat = 1'b0; step();
    beat_pulse();
    beat_pulse();
    key_valid = 1'b0; record = 1'b0; step(4);
    check("coinc_count", log_addr.size() - base, 3);
    check_log("coinc_e0", base, 0, 7'd0, 16'h1482);
    check_log("coinc_e1", base, 1, 7'd1, 16'h1683);
    check_log("coinc_end", base, 2, 7'd2, 16'h0000);

    // Tap shorter than a beat
    base = log_addr.size();
    song = 2'd1; record = 1'b1; step();
    key_valid = 1'b1; key_note = 6'd7; key_meta = 3'd0; step(3);
    key_valid = 1'b0; step(2);
    beat_pulse();
    beat_pulse();
    record = 1'b0; step(4);
`ifdef RECORDER_GLITCH_FILTER_EN
    check("tap_count", log_addr.size() - base, 2);
    check_log("tap_rest", base, 0, 7'd32, 16'h8002);
    check_log("tap_end", base, 1, 7'd33, 16'h0000);
    check("tap_num", {27'd0, num_entries}, 32'd1);
`else
    check("tap_count", log_addr.size() - base, 3);
    check_log("tap_note", base, 0, 7'd32, 16'h0E01);
    check_log("tap_rest", base, 1, 7'd33, 16'h8002);
    check_log("tap_end", base, 2, 7'd34, 16'h0000);
    check("tap_num", {27'd0, num_entries}, 32'd2);
`endif

    // Reset in the middle of HOLD aborts without an end marker
    base = log_addr.size(); dbase = done_cnt;
    song = 2'd2; record = 1'b1; step();
    key_valid = 1'b1; key_note = 6'd9; key_meta = 3'd3; step();
    beat_pulse();
    key_note = 6'd12; step(2);
    check("rst_pre", {30'd0, busy, (num_entries == 5'd1)}, 32'd3);
    beat_pulse();
    reset = 1'b0; record = 1'b0; key_valid = 1'b0;
    #1;
    check("rst_now", {1'b0, wr_en, wr_addr, wr_data, busy, rec_done, num_entries}, 32'd0);
    step(3);
    reset = 1'b1;
    step(5);
    check("rst_count", log_addr.size() - base, 1);
    check_log("rst_e0", base, 0, 7'd64, 16'h12C1);
    check("rst_done", done_cnt - dbase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
